// File: rtl/fft_pkg.sv
// Shared FFT types and helpers: packed complex word, Q1.15 sample, bank state codes
// and the bit-reversal used for decimation-in-time input ordering.
package fft_pkg;
  localparam int WIDTH = 32;
  localparam int HALF  = WIDTH / 2;

  typedef logic signed [HALF-1:0] sample_t;
  typedef logic [WIDTH-1:0]       cplx_t;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  // Reverse the low nbits of idx (nbits <= 10).
  function automatic logic [9:0] bitrev(input logic [9:0] idx, input int unsigned nbits);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = idx[9-i];
    return r >> (10 - nbits);
  endfunction
endpackage

// File: rtl/fft_inbuf_bank.sv
// One sample bank: N x HALF-bit registers, one synchronous write port, two comb reads.
module fft_inbuf_bank #(
  parameter int LOG2N = 3,
  parameter int HALF  = 16
) (
  input  logic             clk,
  input  logic             we,
  input  logic [LOG2N-1:0] waddr,
  input  logic [HALF-1:0]  wdata,
  input  logic [LOG2N-1:0] raddr_a,
  input  logic [LOG2N-1:0] raddr_b,
  output logic [HALF-1:0]  rdata_a,
  output logic [HALF-1:0]  rdata_b
);
  localparam int N = 2 ** LOG2N;

  logic [N-1:0][HALF-1:0] mem;

  // Contents are deliberately not reset; the bank state in the top gates their use.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/fft_input_buffer.sv
// Ping-pong input buffer feeding first-stage DIT butterflies with bit-reversed pairs.
// Build option FFT_INBUF_HALF_EN: store sample_in >>> 1 for one bit of growth headroom.
module fft_input_buffer
  import fft_pkg::*;
#(
  parameter int LOG2N = 3,
  parameter int WIDTH = fft_pkg::WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH/2-1:0] sample_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic [WIDTH-1:0]        out_a,
  output logic [WIDTH-1:0]        out_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    overrun
);
  localparam int N    = 2 ** LOG2N;
  localparam int HALF = WIDTH / 2;
  localparam int NP   = N / 2;

  logic [1:0]       bank_st;
  logic             wr_bank, rd_bank;
  logic [LOG2N-1:0] wr_cnt, wr_addr;
  logic [LOG2N-2:0] rd_k;
  logic             wr_hs, rd_hs;
  logic signed [HALF-1:0] wdata;
  logic [1:0]             we;
  logic [1:0][HALF-1:0]   rd_a, rd_b;

  assign sample_ready = (bank_st[wr_bank] == EMPTY);
  assign out_valid    = (bank_st[rd_bank] == FULL);
  assign wr_hs        = sample_valid && sample_ready;
  assign rd_hs        = out_valid && out_ready;
  assign overrun      = sample_valid && !sample_ready;
  assign out_last     = out_valid && (rd_k == (LOG2N-1)'(NP-1));
  assign wr_addr      = LOG2N'(bitrev(10'(wr_cnt), LOG2N));

`ifdef FFT_INBUF_HALF_EN
  assign wdata = sample_in >>> 1;
`else
  assign wdata = sample_in;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign we[b] = wr_hs && (wr_bank == 1'(b));
    fft_inbuf_bank #(.LOG2N(LOG2N), .HALF(HALF)) u_bank (
      .clk     (clk),
      .we      (we[b]),
      .waddr   (wr_addr),
      .wdata   (wdata),
      .raddr_a ({rd_k, 1'b0}),
      .raddr_b ({rd_k, 1'b1}),
      .rdata_a (rd_a[b]),
      .rdata_b (rd_b[b])
    );
  end

  // Im field is always zero; data is forced to zero whenever no pair is presented.
  assign out_a = out_valid ? {rd_a[rd_bank], {HALF{1'b0}}} : '0;
  assign out_b = out_valid ? {rd_b[rd_bank], {HALF{1'b0}}} : '0;

  // Writer only ever holds an EMPTY bank and reader a FULL one, so the two
  // bank_st updates below never collide on the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st <= {EMPTY, EMPTY};
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_k    <= '0;
    end else begin
      if (wr_hs) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == LOG2N'(N-1)) begin
          bank_st[wr_bank] <= FULL;
          wr_bank          <= ~wr_bank;
        end
      end
      if (rd_hs) begin
        rd_k <= rd_k + 1'b1;
        if (out_last) begin
          bank_st[rd_bank] <= EMPTY;
          rd_bank          <= ~rd_bank;
        end
      end
    end
  end
endmodule
